beta_shift_ctrl: RTL and testbench

Issue-side controller for the sequential shift unit (beta_shift_unit). It accepts shift requests from the execute stage over a valid/ready handshake and handles 0- and 1-bit shifts combinationally in one cycle. Shifts of 2 or more bits are dispatched to the shift unit: the controller holds shu_en_o, detects completion from shu_busy_i, captures the result and returns it over a valid/ready response channel. It also drives the pipeline stall signal and guards against a hung shift unit with a timeout.

---
 rtl/beta_shift_ctrl.sv | 134 +++++++++++++
 tb/tb_beta_shift_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/beta_shift_ctrl.sv
// Issue-side controller for the sequential shift unit.
// Shifts of 0 or 1 bit are answered locally; longer shifts go to the shift unit, guarded by a timeout.
module beta_shift_ctrl #(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 40
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_operand_a_i,
    input  logic [4:0]           req_operand_b_i,
    input  logic [1:0]           req_mode_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DataWidth-1:0] resp_result_o,
    output logic                 resp_err_o,
    output logic                 busy_o,
    output logic [DataWidth-1:0] shu_operand_a_o,
    output logic [4:0]           shu_operand_b_o,
    output logic [1:0]           shu_mode_o,
    output logic                 shu_en_o,
    input  logic                 shu_busy_i,
    input  logic [DataWidth-1:0] shu_result_i
);

    localparam logic [1:0] SHIFT_LEFT   = 2'd0;
    localparam logic [1:0] SHIFT_RIGHT  = 2'd1;
    localparam logic [1:0] SHIFT_ARIGHT = 2'd2;
    localparam int         CntWidth     = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t                state;
    logic [CntWidth-1:0]   timeout_cnt;
    logic                  busy_seen;
    logic                  mode_legal;
    logic                  completion;
    logic                  timed_out;
    logic [DataWidth-1:0]  one_bit_result;

    assign mode_legal  = (req_mode_i == SHIFT_LEFT) || (req_mode_i == SHIFT_RIGHT) ||
                         (req_mode_i == SHIFT_ARIGHT);
    assign completion  = busy_seen && !shu_busy_i;
    assign timed_out   = timeout_cnt >= CntWidth'(TimeoutCycles - 1);

    assign req_ready_o = (state == IDLE);
    assign shu_en_o    = (state == RUN);
    assign busy_o      = (state == RUN) || ((state == RESP) && !resp_ready_i);

    always_comb begin
        one_bit_result = {req_operand_a_i[DataWidth-1], req_operand_a_i[DataWidth-1:1]};
        case (req_mode_i)
            SHIFT_LEFT:  one_bit_result = {req_operand_a_i[DataWidth-2:0], 1'b0};
            SHIFT_RIGHT: one_bit_result = {1'b0, req_operand_a_i[DataWidth-1:1]};
            default:     one_bit_result = {req_operand_a_i[DataWidth-1], req_operand_a_i[DataWidth-1:1]};
        endcase
    end

    // Completion is checked before the timeout so a shift finishing on the last allowed cycle still succeeds.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            resp_valid_o    <= 1'b0;
            resp_err_o      <= 1'b0;
            resp_result_o   <= '0;
            shu_operand_a_o <= '0;
            shu_operand_b_o <= '0;
            shu_mode_o      <= '0;
            timeout_cnt     <= '0;
            busy_seen       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (!mode_legal) begin
                            resp_err_o    <= 1'b1;
                            resp_result_o <= '0;
                            resp_valid_o  <= 1'b1;
                            state         <= RESP;
                        end else if (req_operand_b_i == 5'd0) begin
                            resp_err_o    <= 1'b0;
                            resp_result_o <= req_operand_a_i;
                            resp_valid_o  <= 1'b1;
                            state         <= RESP;
                        end else if (req_operand_b_i == 5'd1) begin
                            resp_err_o    <= 1'b0;
                            resp_result_o <= one_bit_result;
                            resp_valid_o  <= 1'b1;
                            state         <= RESP;
                        end else begin
                            shu_operand_a_o <= req_operand_a_i;
                            shu_operand_b_o <= req_operand_b_i;
                            shu_mode_o      <= req_mode_i;
                            timeout_cnt     <= '0;
                            busy_seen       <= 1'b0;
                            state           <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (shu_busy_i) begin
                        busy_seen <= 1'b1;
                    end
                    if (timeout_cnt != CntWidth'(TimeoutCycles)) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                    if (completion) begin
                        resp_result_o <= shu_result_i;
                        resp_err_o    <= 1'b0;
                        resp_valid_o  <= 1'b1;
                        state         <= RESP;
                    end else if (timed_out) begin
                        resp_result_o <= '0;
                        resp_err_o    <= 1'b1;
                        resp_valid_o  <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    resp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beta_shift_ctrl.sv
// Self-checking bench for beta_shift_ctrl with a behavioural shift-unit stub and a reference shift model.
module tb_beta_shift_ctrl;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [DW-1:0] req_operand_a_i = '0;
    logic [4:0]    req_operand_b_i = '0;
    logic [1:0]    req_mode_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b1;
    logic [DW-1:0] resp_result_o;
    logic          resp_err_o;
    logic          busy_o;
    logic [DW-1:0] shu_operand_a_o;
    logic [4:0]    shu_operand_b_o;
    logic [1:0]    shu_mode_o;
    logic          shu_en_o;
    logic          shu_busy_i;
    logic [DW-1:0] shu_result_i;

    int   tests = 0;
    int   failures = 0;
    logic stub_stuck = 1'b0;
    int   su_k = 0;
    logic su_busy = 1'b0;

    beta_shift_ctrl #(.DataWidth(DW), .TimeoutCycles(40)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_operand_a_i(req_operand_a_i), .req_operand_b_i(req_operand_b_i),
        .req_mode_i(req_mode_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .resp_err_o(resp_err_o),
        .busy_o(busy_o),
        .shu_operand_a_o(shu_operand_a_o), .shu_operand_b_o(shu_operand_b_o),
        .shu_mode_o(shu_mode_o), .shu_en_o(shu_en_o),
        .shu_busy_i(shu_busy_i), .shu_result_i(shu_result_i)
    );

    always #5 clk_i = ~clk_i;

    // Mode 0 = left, 1 = logical right, 2 = arithmetic right, 3 = illegal.
    function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] a, input int b, input logic [1:0] mode);
        case (mode)
            2'd0:    return a << b;
            2'd1:    return a >> b;
            2'd2:    return $unsigned($signed(a) >>> b);
            default: return '0;
        endcase
    endfunction

    // Shift unit stub: busy rises one cycle after enable and falls b cycles after it.
    always @(posedge clk_i) begin
        if (!rstn_i || !shu_en_o) begin
            su_k    <= 0;
            su_busy <= 1'b0;
        end else begin
            su_k    <= su_k + 1;
            su_busy <= (su_k + 1) < int'(shu_operand_b_o);
        end
    end

    assign shu_busy_i   = stub_stuck ? 1'b1 : su_busy;
    assign shu_result_i = ref_shift(shu_operand_a_o, int'(shu_operand_b_o), shu_mode_o);

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] a, input logic [4:0] b,
                                 input logic [1:0] mode, input int hold);
        int            cycles;
        int            en_cycles;
        int            exp_en;
        logic          exp_err;
        logic [DW-1:0] exp_result;
        exp_err    = (mode == 2'd3) || (stub_stuck && b >= 5'd2);
        exp_result = exp_err ? '0 : ref_shift(a, int'(b), mode);
        exp_en     = (mode == 2'd3 || b < 5'd2) ? 0 : (stub_stuck ? 40 : int'(b) + 1);
        cycles     = 0;
        en_cycles  = 0;

        @(negedge clk_i);
        checkOutput("req_ready_idle", {31'd0, req_ready_o}, 1);
        req_valid_i     = 1'b1;
        req_operand_a_i = a;
        req_operand_b_i = b;
        req_mode_i      = mode;
        resp_ready_i    = (hold == 0);
        @(negedge clk_i);
        req_valid_i = 1'b0;

        while (!resp_valid_o && cycles < 200) begin
            if (shu_en_o) begin
                en_cycles++;
                if (en_cycles == 1) begin
                    checkOutput("shu_a", shu_operand_a_o, a);
                    checkOutput("shu_b", {27'd0, shu_operand_b_o}, {27'd0, b});
                    checkOutput("shu_mode", {30'd0, shu_mode_o}, {30'd0, mode});
                end
                checkOutput("busy_run", {31'd0, busy_o}, 1);
            end
            @(negedge clk_i);
            cycles++;
        end

        checkOutput("resp_valid", {31'd0, resp_valid_o}, 1);
        checkOutput("latency", cycles, exp_en);
        checkOutput("en_cycles", en_cycles, exp_en);
        checkOutput("result", resp_result_o, exp_result);
        checkOutput("err", {31'd0, resp_err_o}, {31'd0, exp_err});
        checkOutput("en_resp", {31'd0, shu_en_o}, 0);
        checkOutput("busy_resp", {31'd0, busy_o}, {31'd0, hold > 0});

        for (int i = 0; i < hold; i++) begin
            req_valid_i     = 1'b1;
            req_operand_a_i = $urandom;
            req_operand_b_i = 5'd0;
            req_mode_i      = 2'd0;
            @(negedge clk_i);
            checkOutput("hold_valid", {31'd0, resp_valid_o}, 1);
            checkOutput("hold_result", resp_result_o, exp_result);
            checkOutput("hold_err", {31'd0, resp_err_o}, {31'd0, exp_err});
            checkOutput("hold_busy", {31'd0, busy_o}, 1);
            checkOutput("hold_req_ready", {31'd0, req_ready_o}, 0);
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("valid_cleared", {31'd0, resp_valid_o}, 0);
        checkOutput("req_ready_after", {31'd0, req_ready_o}, 1);
        checkOutput("busy_after", {31'd0, busy_o}, 0);
    endtask

    initial begin
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_resp_valid", {31'd0, resp_valid_o}, 0);
        checkOutput("rst_resp_err", {31'd0, resp_err_o}, 0);
        checkOutput("rst_resp_result", resp_result_o, 0);
        checkOutput("rst_shu_en", {31'd0, shu_en_o}, 0);
        checkOutput("rst_shu_a", shu_operand_a_o, 0);
        checkOutput("rst_shu_b", {27'd0, shu_operand_b_o}, 0);
        checkOutput("rst_shu_mode", {30'd0, shu_mode_o}, 0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rst_req_ready", {31'd0, req_ready_o}, 1);
        checkOutput("rst_busy", {31'd0, busy_o}, 0);

        applyStimulus(32'h0000_00F0, 5'd0, 2'd0, 0);
        applyStimulus(32'h8000_0001, 5'd1, 2'd2, 0);
        applyStimulus(32'h8000_0001, 5'd1, 2'd1, 0);
        applyStimulus(32'h8000_0001, 5'd1, 2'd0, 0);
        applyStimulus(32'h0000_0001, 5'd31, 2'd0, 0);
        applyStimulus(32'h8000_0000, 5'd4, 2'd2, 0);
        applyStimulus(32'h8000_0000, 5'd2, 2'd1, 0);
        applyStimulus(32'h1234_5678, 5'd5, 2'd0, 10);
        applyStimulus(32'hCAFE_F00D, 5'd3, 2'd2, 0);
        applyStimulus(32'hDEAD_BEEF, 5'd7, 2'd3, 0);

        stub_stuck = 1'b1;
        applyStimulus(32'hFFFF_0000, 5'd10, 2'd1, 2);
        stub_stuck = 1'b0;

        for (int n = 0; n < 24; n++) begin
            applyStimulus($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a long shift must abandon it without a response.
        @(negedge clk_i);
        req_valid_i     = 1'b1;
        req_operand_a_i = 32'h0000_00FF;
        req_operand_b_i = 5'd20;
        req_mode_i      = 2'd0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checkOutput("midrun_en", {31'd0, shu_en_o}, 1);
        rstn_i = 1'b0;
        @(negedge clk_i);
        checkOutput("midrun_rst_en", {31'd0, shu_en_o}, 0);
        checkOutput("midrun_rst_valid", {31'd0, resp_valid_o}, 0);
        rstn_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            checkOutput("post_rst_no_resp", {31'd0, resp_valid_o}, 0);
            checkOutput("post_rst_no_en", {31'd0, shu_en_o}, 0);
        end
        applyStimulus(32'h0000_0003, 5'd6, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
